letter_sequencer: RTL and testbench

Upstream stage of the 7-segment letter display path. It keeps the current letter (A, B or C) in a small state machine and advances it either automatically, from a prescaled counter, or manually, from a synchronized step input. It drives the 6-bit letter code consumed by the downstream letter decoder (A=6'b100000, B=6'b101000, C=6'b110000) and shows the current letter one-hot on the green LEDs.

---
 rtl/letter_sequencer.sv | 110 +++++++++++
 tb/tb_letter_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/letter_sequencer.sv
// Letter sequencer: holds the current letter (A/B/C) and advances it from a
// prescaled auto-step counter or a synchronized manual STEP edge.
module letter_sequencer #(
    parameter int DIV = 50_000_000
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       RUN,
    input  logic       STEP,
    input  logic       DIR,
    output logic [5:0] CODE,
    output logic [2:0] LEDG,
    output logic       TICK
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    localparam logic [1:0] S_A = 2'b00;
    localparam logic [1:0] S_B = 2'b01;
    localparam logic [1:0] S_C = 2'b10;

    logic [CW-1:0] r_cnt;
    logic          r_sync1;
    logic          r_sync2;
    logic          r_prev;
    logic [1:0]    r_state;
    logic [5:0]    r_code;
    logic [2:0]    r_ledg;
    logic          r_tick;

    logic          w_auto;
    logic          w_step;
    logic          w_adv;
    logic [CW-1:0] w_cnt_next;
    logic [1:0]    w_state_next;
    logic [5:0]    w_code_next;
    logic [2:0]    w_ledg_next;

    assign w_auto = RUN && (r_cnt == CNT_MAX);
    assign w_step = r_sync2 & ~r_prev;
    assign w_adv  = w_auto | w_step;

    // A step event restarts the prescaler so the next auto advance is a full period away.
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_step) begin
            w_cnt_next = '0;
        end else if (RUN) begin
            w_cnt_next = w_auto ? '0 : r_cnt + CW'(1);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_A:     if (w_adv) w_state_next = DIR ? S_C : S_B;
            S_B:     if (w_adv) w_state_next = DIR ? S_A : S_C;
            S_C:     if (w_adv) w_state_next = DIR ? S_B : S_A;
            default: w_state_next = S_A;
        endcase
    end

    // Outputs are decoded from the next state so they update on the same edge as the state.
    always_comb begin
        w_code_next = 6'b100000;
        w_ledg_next = 3'b001;
        case (w_state_next)
            S_B: begin
                w_code_next = 6'b101000;
                w_ledg_next = 3'b010;
            end
            S_C: begin
                w_code_next = 6'b110000;
                w_ledg_next = 3'b100;
            end
            default: begin
                w_code_next = 6'b100000;
                w_ledg_next = 3'b001;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_cnt   <= '0;
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_state <= S_A;
            r_code  <= 6'b100000;
            r_ledg  <= 3'b001;
            r_tick  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_sync1 <= STEP;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_state <= w_state_next;
            r_code  <= w_code_next;
            r_ledg  <= w_ledg_next;
            r_tick  <= w_auto;
        end
    end

    assign CODE = r_code;
    assign LEDG = r_ledg;
    assign TICK = r_tick;

endmodule

// File: tb/tb_letter_sequencer.sv
// Bench for letter_sequencer: directed scenarios plus random traffic, checked
// against a letter-index model on two instances (DIV=4 and DIV=1).
module tb_letter_sequencer;

    logic       clk;
    logic       rst;
    logic       run;
    logic       step;
    logic       dir;
    logic [5:0] code4, code1;
    logic [2:0] ledg4, ledg1;
    logic       tick4, tick1;

    int n_tests = 0;
    int n_fail  = 0;

    letter_sequencer #(.DIV(4)) u_div4 (
        .CLOCK_50(clk), .RESET(rst), .RUN(run), .STEP(step), .DIR(dir),
        .CODE(code4), .LEDG(ledg4), .TICK(tick4)
    );

    letter_sequencer #(.DIV(1)) u_div1 (
        .CLOCK_50(clk), .RESET(rst), .RUN(run), .STEP(step), .DIR(dir),
        .CODE(code1), .LEDG(ledg1), .TICK(tick1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: letter index 0=A,1=B,2=C; STEP sample history from past edges.
    int DIVS[2] = '{4, 1};
    int m_letter[2];
    int m_cnt[2];
    bit m_tick[2];
    bit h1, h2, h3;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_letter[d] = 0;
            m_cnt[d]    = 0;
            m_tick[d]   = 1'b0;
        end
        h1 = 1'b0;
        h2 = 1'b0;
        h3 = 1'b0;
    endtask

    task automatic model_edge();
        bit sev;
        bit aev;
        sev = h2 & ~h3;
        for (int d = 0; d < 2; d++) begin
            aev = run && (m_cnt[d] == DIVS[d] - 1);
            if (sev)
                m_cnt[d] = 0;
            else if (run)
                m_cnt[d] = aev ? 0 : m_cnt[d] + 1;
            if (aev || sev)
                m_letter[d] = (m_letter[d] + (dir ? 2 : 1)) % 3;
            m_tick[d] = aev;
        end
        h3 = h2;
        h2 = h1;
        h1 = step;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string seg);
        logic [5:0] ec;
        logic [2:0] el;
        for (int d = 0; d < 2; d++) begin
            ec = 6'b100000 | 6'(m_letter[d] << 3);
            el = 3'(1 << m_letter[d]);
            check($sformatf("%s/div%0d/CODE", seg, DIVS[d]), {2'b00, (d == 0) ? code4 : code1}, {2'b00, ec});
            check($sformatf("%s/div%0d/LEDG", seg, DIVS[d]), {5'b0, (d == 0) ? ledg4 : ledg1}, {5'b0, el});
            check($sformatf("%s/div%0d/TICK", seg, DIVS[d]), {7'b0, (d == 0) ? tick4 : tick1}, {7'b0, m_tick[d]});
        end
    endtask

    task automatic cycle(input string seg);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(seg);
    endtask

    // Called at posedge+1; asserts reset between edges and releases it at posedge+1.
    task automatic apply_reset(input string seg);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check({seg, "/rst_code"}, {2'b00, code4}, 8'h20);
        check({seg, "/rst_ledg"}, {5'b0, ledg4}, 8'h01);
        check({seg, "/rst_tick"}, {7'b0, tick4}, 8'h00);
        compare_all({seg, "/rst"});
        @(posedge clk);
        #1;
        compare_all({seg, "/rst_hold"});
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        run  = 1'b0;
        step = 1'b0;
        dir  = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        apply_reset("init");

        // Forward auto stepping, advance every 4 cycles
        run = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            cycle("fwd");
            check($sformatf("fwd_tick_c%0d", c), {7'b0, tick4}, {7'b0, (c % 4 == 0 && c <= 12)});
            if (c == 4)  check("fwd_code_c4",  {2'b00, code4}, 8'h28);
            if (c == 8)  check("fwd_code_c8",  {2'b00, code4}, 8'h30);
            if (c == 12) check("fwd_code_c12", {2'b00, code4}, 8'h20);
        end

        // Reset mid-run, then reverse and a direction flip
        apply_reset("midrun");
        dir = 1'b1;
        for (int c = 0; c < 12; c++) cycle("rev");
        check("rev_back_to_A", {2'b00, code4}, 8'h20);
        for (int c = 0; c < 5; c++) cycle("rev2");
        dir = 1'b0;
        for (int c = 0; c < 9; c++) cycle("flip");

        // Manual step held for 20 cycles, then a second press
        apply_reset("man");
        run  = 1'b0;
        step = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            cycle("man_hold");
            check($sformatf("man_code_c%0d", c), {2'b00, code4}, (c >= 3) ? 8'h28 : 8'h20);
        end
        step = 1'b0;
        for (int c = 0; c < 4; c++) cycle("man_rel");
        step = 1'b1;
        for (int c = 0; c < 5; c++) cycle("man_press2");
        check("man_second_C", {2'b00, code4}, 8'h30);
        step = 1'b0;
        for (int c = 0; c < 3; c++) cycle("man_rel2");

        // Pause with cnt=2, resume: advance exactly 2 cycles later
        apply_reset("pause");
        run = 1'b1;
        cycle("pause_run");
        cycle("pause_run");
        run = 1'b0;
        for (int c = 0; c < 10; c++) cycle("pause_hold");
        run = 1'b1;
        cycle("pause_resume");
        check("pause_no_tick_1", {7'b0, tick4}, 8'h00);
        cycle("pause_resume");
        check("pause_tick_2", {7'b0, tick4}, 8'h01);
        check("pause_code_2", {2'b00, code4}, 8'h28);

        // Collision: step event lands in the cnt=3 cycle
        apply_reset("coll");
        run = 1'b1;
        cycle("coll");
        step = 1'b1;
        cycle("coll");
        step = 1'b0;
        cycle("coll");
        cycle("coll");
        check("coll_code", {2'b00, code4}, 8'h28);
        check("coll_tick", {7'b0, tick4}, 8'h01);
        for (int c = 5; c <= 8; c++) begin
            cycle("coll_next");
            check($sformatf("coll_tick_c%0d", c), {7'b0, tick4}, {7'b0, c == 8});
        end
        check("coll_next_code", {2'b00, code4}, 8'h30);

        // STEP held through reset release gives one event ~3 clocks later
        step = 1'b1;
        run  = 1'b0;
        apply_reset("stephold");
        for (int c = 1; c <= 6; c++) cycle("stephold");
        check("stephold_code", {2'b00, code4}, 8'h28);
        step = 1'b0;

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            run = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) dir = ~dir;
            if ($urandom_range(0, 5) == 0) step = ~step;
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
